// File: rtl/ram_burst_master.sv
// ram_burst_master: burst command controller for a single-port synchronous RAM
module ram_burst_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 8,
  parameter int MEM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [MEM_WIDTH-1:0]  wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [MEM_WIDTH-1:0]  rdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic                  rdata_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wr_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [MEM_WIDTH-1:0]  mem_rd_data
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_OUT} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d, addr_nxt;
  logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
  logic last;
  always_comb begin
    addr_nxt = (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
    last = cnt_q == '0;
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && cmd_valid) begin
      state_d = cmd_wr ? WR : RD_ISSUE;
      addr_d = cmd_addr;
      cnt_d = cmd_len;
    end
    if (state_q == WR && wdata_valid) begin
      state_d = last ? IDLE : WR;
      addr_d = addr_nxt;
      cnt_d = cnt_q - 1'b1;
    end
    if (state_q == RD_ISSUE) state_d = RD_WAIT;
    if (state_q == RD_WAIT) begin
      state_d = RD_OUT;
      rdata_d = mem_rd_data;
    end
    // the final read beat leaves the address on the last word read
    if (state_q == RD_OUT && rdata_ready) begin
      state_d = last ? IDLE : RD_ISSUE;
      addr_d = last ? addr_q : addr_nxt;
      cnt_d = last ? cnt_q : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  // outputs are forced idle while rst is high so an abandoned burst strobes nothing
  always_comb begin
    cmd_ready = !rst && state_q == IDLE;
    busy = !rst && state_q != IDLE;
    wdata_ready = !rst && state_q == WR;
    mem_wren = wdata_ready && wdata_valid;
    mem_wr_data = wdata_ready ? wdata : '0;
    mem_rden = !rst && state_q == RD_ISSUE;
    rdata_valid = !rst && state_q == RD_OUT;
    rdata_last = rdata_valid && last;
    mem_addr = addr_q;
    rdata = rdata_q;
  end
endmodule
